// File: rtl/toi2s_pkg.sv
// Shared types and constants for the toi2s rxin serial receiver.
// Optional build macro: RXIN_PARITY_EN (adds the even-parity bit and PARITY state).
package toi2s_pkg;

  localparam int RX_DATA_W = 8;

  // Receiver FSM states; PARITY only exists when the parity bit is framed.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
`ifdef RXIN_PARITY_EN
    RX_PARITY    = 3'd5,
`endif
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Saturating increment for the 8-bit rejected-frame counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return 8'hFF;
    end else begin
      return value + 8'd1;
    end
  endfunction

`ifdef RXIN_PARITY_EN
  // Even parity: data bits XOR parity bit must be zero for a good frame.
  function automatic logic even_parity_ok(input logic [RX_DATA_W-1:0] data,
                                          input logic                 par);
    return ~((^data) ^ par);
  endfunction
`endif

endpackage

// File: rtl/rxin_sync.sv
// Two-flop synchronizer for the asynchronous rxin pin plus a falling-edge
// detector built from a third delay flop. All flops reset to the idle level.
module rxin_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxin,
  output logic rxs,
  output logic fall
);

  logic meta_q;
  logic rxs_q;
  logic rxs_dly_q;

  // Resynchronise rxin and keep one extra delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q    <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
    end else begin
      meta_q    <= rxin;
      rxs_q     <= meta_q;
      rxs_dly_q <= rxs_q;
    end
  end

  assign rxs  = rxs_q;
  assign fall = rxs_dly_q & ~rxs_q;

endmodule

// File: rtl/rxin_uart_rx.sv
// Serial byte receiver for the rxin pin, feeding the PWM duty_cycle input.
// Default frame is 8N1 (LSB first, idle high) at CLKS_PER_BIT clocks per bit.
// Build macro RXIN_PARITY_EN switches to 8E1 and adds the parity_err strobe.
// All outputs come straight from flops; nothing is combinational from rxin.
module rxin_uart_rx
  import toi2s_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxin,
  output logic [RX_DATA_W-1:0] data_out,
  output logic                 data_valid,
  output logic [RX_DATA_W-1:0] duty_cycle,
  output logic                 frame_err,
`ifdef RXIN_PARITY_EN
  output logic                 parity_err,
`endif
  output logic [7:0]           err_cnt,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Half-bit load centres the start-bit sample; full-bit load steps bit to bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic rxs_s;
  logic fall_s;

  rx_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_idx_q;
  logic [RX_DATA_W-1:0] shreg_q;
  logic [RX_DATA_W-1:0] data_out_q;
  logic [RX_DATA_W-1:0] duty_cycle_q;
  logic                 data_valid_q;
  logic                 frame_err_q;
  logic [7:0]           err_cnt_q;
  logic                 busy_q;
`ifdef RXIN_PARITY_EN
  logic                 par_bit_q;
  logic                 parity_err_q;
`endif

  logic [RX_DATA_W-1:0] shreg_d;
  logic [7:0]           err_cnt_d;
  logic                 stop_good_s;
  logic                 cnt_zero_s;

  rxin_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rxin  (rxin),
    .rxs   (rxs_s),
    .fall  (fall_s)
  );

  // Next shift value, saturated error count and good-frame decision at the stop sample.
  always_comb begin
    shreg_d     = {rxs_s, shreg_q[RX_DATA_W-1:1]};
    err_cnt_d   = sat_inc8(err_cnt_q);
    cnt_zero_s  = (cnt_q == '0);
`ifdef RXIN_PARITY_EN
    stop_good_s = rxs_s & even_parity_ok(shreg_q, par_bit_q);
`else
    stop_good_s = rxs_s;
`endif
  end

  // Receiver FSM with bit timing, byte assembly and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      duty_cycle_q <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= 8'h00;
      busy_q       <= 1'b0;
`ifdef RXIN_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef RXIN_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        RX_IDLE: begin
          // Only a true high-to-low edge starts a frame; a held low is ignored.
          if (fall_s) begin
            state_q <= RX_START;
            cnt_q   <= CNT_HALF;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        RX_START: begin
          if (cnt_zero_s) begin
            if (!rxs_s) begin
              state_q   <= RX_DATA;
              cnt_q     <= CNT_FULL;
              bit_idx_q <= 3'd0;
            end else begin
              // Line went high again before mid-bit: a glitch, not a start bit.
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        RX_DATA: begin
          if (cnt_zero_s) begin
            shreg_q <= shreg_d;
            cnt_q   <= CNT_FULL;
            if (bit_idx_q == 3'd7) begin
`ifdef RXIN_PARITY_EN
              state_q <= RX_PARITY;
`else
              state_q <= RX_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

`ifdef RXIN_PARITY_EN
        RX_PARITY: begin
          if (cnt_zero_s) begin
            par_bit_q <= rxs_s;
            cnt_q     <= CNT_FULL;
            state_q   <= RX_STOP;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
`endif

        RX_STOP: begin
          if (cnt_zero_s) begin
            if (stop_good_s) begin
              data_valid_q <= 1'b1;
              data_out_q   <= shreg_q;
              duty_cycle_q <= shreg_q;
              state_q      <= RX_IDLE;
              busy_q       <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              err_cnt_q   <= err_cnt_d;
`ifdef RXIN_PARITY_EN
              parity_err_q <= ~even_parity_ok(shreg_q, par_bit_q);
`endif
              // A low stop bit means the line may be in break; wait for idle.
              if (rxs_s) begin
                state_q <= RX_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= RX_WAIT_HIGH;
              end
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        RX_WAIT_HIGH: begin
          if (rxs_s) begin
            state_q <= RX_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RX_WAIT_HIGH;
          end
        end

        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign duty_cycle = duty_cycle_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;
  assign busy       = busy_q;
`ifdef RXIN_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_rxin_uart_rx.sv
// Self-checking bench for rxin_uart_rx at 16 clocks per bit.
// Expected strobes come from a frame-level model: a frame with a high stop bit
// (and good parity when RXIN_PARITY_EN) yields its byte, anything else bumps a
// saturating error count and leaves the held byte alone.
module tb_rxin_uart_rx;

  localparam int CPB = 16;
`ifdef RXIN_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Pin edge to visible strobe: 2 sync flops + edge cycle + half bit + full bits + output flop.
  localparam int unsigned LAT_MIN = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;
  localparam int unsigned LAT_MAX = LAT_MIN + 1;

  logic       clk;
  logic       reset;
  logic       rxin;
  logic [7:0] data_out;
  logic       data_valid;
  logic [7:0] duty_cycle;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;
  logic       perr_s;
`ifdef RXIN_PARITY_EN
  logic       parity_err;
  assign perr_s = parity_err;
`else
  assign perr_s = 1'b0;
`endif

  rxin_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxin       (rxin),
    .data_out   (data_out),
    .data_valid (data_valid),
    .duty_cycle (duty_cycle),
    .frame_err  (frame_err),
`ifdef RXIN_PARITY_EN
    .parity_err (parity_err),
`endif
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  typedef struct {
    bit          is_err;
    bit          perr;
    logic [7:0]  dout;
    logic [7:0]  duty;
    logic [7:0]  ecnt;
    int unsigned cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    bit         exp_err;
    logic [7:0] exp_dout;
    logic [7:0] exp_duty;
    logic [7:0] exp_ecnt;
  } vec_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  vec_t        tbl[7];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;
  logic [7:0]  m_dout, m_duty, m_ecnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp strobes.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe together with the held outputs seen alongside it.
  always @(negedge clk) begin
    if (!reset && data_valid) obs_q.push_back('{1'b0, perr_s, data_out, duty_cycle, err_cnt, cyc});
    if (!reset && frame_err)  obs_q.push_back('{1'b1, perr_s, data_out, duty_cycle, err_cnt, cyc});
  end

  // Hard stop if anything hangs.
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: run did not complete, passed %0d of %0d", n_pass, n_checks);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rxin = v;
    tick(CPB);
  endtask

  task automatic send_raw(input logic [7:0] d, input logic par, input logic stop,
                          output int unsigned t_start);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RXIN_PARITY_EN
    drive_bit(par);
`else
    if (par !== par) drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int unsigned t_start);
    send_raw(d, ^d, stop, t_start);
  endtask

  // Frame-level reference: good frames update the held byte, bad ones count.
  task automatic model_frame(input logic [7:0] d, input bit good, input bit perr);
    if (good) begin
      m_dout = d;
      m_duty = d;
      exp_q.push_back('{1'b0, 1'b0, m_dout, m_duty, m_ecnt, 0});
    end else begin
      m_ecnt = (m_ecnt == 8'hFF) ? 8'hFF : m_ecnt + 8'd1;
      exp_q.push_back('{1'b1, perr, m_dout, m_duty, m_ecnt, 0});
    end
  endtask

  task automatic compare_ev(input string tag, input ev_t o, input ev_t e);
    check({tag, " kind"},     {31'd0, o.is_err}, {31'd0, e.is_err});
    check({tag, " data_out"}, {24'd0, o.dout},   {24'd0, e.dout});
    check({tag, " duty"},     {24'd0, o.duty},   {24'd0, e.duty});
    check({tag, " err_cnt"},  {24'd0, o.ecnt},   {24'd0, e.ecnt});
`ifdef RXIN_PARITY_EN
    check({tag, " parity_err"}, {31'd0, o.perr}, {31'd0, e.perr});
`endif
  endtask

  task automatic flush_compare(input string tag);
    ev_t o, e;
    int  k;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check($sformatf("%s ev%0d present", tag, k), 32'd0, 32'd1);
      end else begin
        o = obs_q.pop_front();
        compare_ev($sformatf("%s ev%0d", tag, k), o, e);
      end
      k++;
    end
    check({tag, " extra strobes"}, obs_q.size(), 32'd0);
    obs_q.delete();
  endtask

  task automatic wait_event(input int budget, output bit ok);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < budget) begin
      tick(1);
      n++;
    end
    ok = (obs_q.size() != 0);
  endtask

  initial begin
    int unsigned ts, t1, t2, lat;
    bit          ok, good;
    ev_t         o;
    logic [7:0]  d;

    //             data   stop gap  err   dout   duty   ecnt
    tbl[0] = '{8'hA5, 1'b1, 16, 1'b0, 8'hA5, 8'hA5, 8'd0};
    tbl[1] = '{8'h3C, 1'b0, 32, 1'b1, 8'hA5, 8'hA5, 8'd1};
    tbl[2] = '{8'h01, 1'b1,  0, 1'b0, 8'h01, 8'h01, 8'd1};
    tbl[3] = '{8'hFE, 1'b1, 16, 1'b0, 8'hFE, 8'hFE, 8'd1};
    tbl[4] = '{8'h00, 1'b0, 24, 1'b1, 8'hFE, 8'hFE, 8'd2};
    tbl[5] = '{8'hFF, 1'b1, 16, 1'b0, 8'hFF, 8'hFF, 8'd2};
    tbl[6] = '{8'h80, 1'b1,  8, 1'b0, 8'h80, 8'h80, 8'd2};

    rxin  = 1'b1;
    reset = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(4);

    // Reset state.
    check("reset data_out",   {24'd0, data_out},   32'h00);
    check("reset duty_cycle", {24'd0, duty_cycle}, 32'h00);
    check("reset err_cnt",    {24'd0, err_cnt},    32'h00);
    check("reset data_valid", {31'd0, data_valid}, 32'd0);
    check("reset frame_err",  {31'd0, frame_err},  32'd0);
    check("reset busy",       {31'd0, busy},       32'd0);

    // Table of frames with hand-computed outputs and strobe latency.
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, ts);
      wait_event(40, ok);
      check($sformatf("tbl%0d strobe seen", i), {31'd0, ok}, 32'd1);
      if (ok) begin
        o   = obs_q.pop_front();
        lat = o.cyc - ts;
        check($sformatf("tbl%0d kind", i),     {31'd0, o.is_err}, {31'd0, tbl[i].exp_err});
        check($sformatf("tbl%0d data_out", i), {24'd0, o.dout},   {24'd0, tbl[i].exp_dout});
        check($sformatf("tbl%0d duty", i),     {24'd0, o.duty},   {24'd0, tbl[i].exp_duty});
        check($sformatf("tbl%0d err_cnt", i),  {24'd0, o.ecnt},   {24'd0, tbl[i].exp_ecnt});
        check($sformatf("tbl%0d latency %0d in window", i, lat),
              {31'd0, (lat >= LAT_MIN && lat <= LAT_MAX)}, 32'd1);
      end
      rxin = 1'b1;
      tick(tbl[i].gap);
    end
    m_dout = tbl[6].exp_dout;
    m_duty = tbl[6].exp_duty;
    m_ecnt = tbl[6].exp_ecnt;
    tick(16);
    flush_compare("after table");

    // Glitch: 3 low cycles start a frame that is abandoned at the start-bit centre.
    rxin = 1'b0;
    tick(3);
    rxin = 1'b1;
    tick(3);
    check("glitch busy raised", {31'd0, busy}, 32'd1);
    tick(8);
    check("glitch busy dropped", {31'd0, busy}, 32'd0);
    tick(30);
    flush_compare("glitch");

    // Framing error followed by a held-low break.
    send_frame(8'h3C, 1'b0, ts);
    model_frame(8'h3C, 1'b0, 1'b0);
    tick(40);
    check("break busy held", {31'd0, busy}, 32'd1);
    flush_compare("ferr");
    check("ferr duty unchanged", {24'd0, duty_cycle}, {24'd0, m_duty});
    rxin = 1'b1;
    tick(6);
    check("break release idle", {31'd0, busy}, 32'd0);
    tick(40);
    flush_compare("break release");

    // Back-to-back frames, no idle gap.
    send_frame(8'h01, 1'b1, t1);
    send_frame(8'hFE, 1'b1, t2);
    model_frame(8'h01, 1'b1, 1'b0);
    model_frame(8'hFE, 1'b1, 1'b0);
    rxin = 1'b1;
    tick(32);
    if (obs_q.size() >= 2)
      check("b2b spacing", obs_q[1].cyc - obs_q[0].cyc, CPB * FRAME_BITS);
    else
      check("b2b strobe count", obs_q.size(), 32'd2);
    flush_compare("b2b");
    check("b2b final duty", {24'd0, duty_cycle}, 32'hFE);

    // Reset during bit 4 discards the frame and clears held outputs.
    tick(16);
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rxin = d[4];
    tick(8);
    reset = 1'b1;
    rxin  = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("midrst data_out",   {24'd0, data_out},   32'h00);
    check("midrst duty_cycle", {24'd0, duty_cycle}, 32'h00);
    check("midrst err_cnt",    {24'd0, err_cnt},    32'h00);
    check("midrst busy",       {31'd0, busy},       32'd0);
    m_dout = 8'h00;
    m_duty = 8'h00;
    m_ecnt = 8'h00;
    tick(200);
    flush_compare("midrst");
    send_frame(8'h55, 1'b1, ts);
    model_frame(8'h55, 1'b1, 1'b0);
    rxin = 1'b1;
    tick(20);
    flush_compare("post reset 0x55");

    // Randomised frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_frame(d, good, ts);
      model_frame(d, good, 1'b0);
      rxin = 1'b1;
      tick(good ? int'($urandom_range(0, 20)) : int'($urandom_range(16, 40)));
    end
    tick(50);
    flush_compare("random");

    // Drive the error counter into saturation.
    for (int i = 0; i < 258; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b0, ts);
      model_frame(d, 1'b0, 1'b0);
      rxin = 1'b1;
      tick(18);
    end
    tick(20);
    flush_compare("saturate");
    check("err_cnt saturated", {24'd0, err_cnt}, 32'hFF);
    check("saturate duty held", {24'd0, duty_cycle}, {24'd0, m_duty});

`ifdef RXIN_PARITY_EN
    // Parity: 0x07 has three ones, so the even parity bit is 1.
    send_raw(8'h07, 1'b0, 1'b1, ts);
    model_frame(8'h07, 1'b0, 1'b1);
    rxin = 1'b1;
    tick(20);
    flush_compare("parity bad");
    send_raw(8'h07, 1'b1, 1'b1, ts);
    model_frame(8'h07, 1'b1, 1'b0);
    rxin = 1'b1;
    tick(20);
    flush_compare("parity good");
    check("parity good data_out", {24'd0, data_out}, 32'h07);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
